// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and control encodings for the multicycle MIPS control unit (MULTICYCLE_INTERRUPT_EN enables interrupt entry)
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, RTYPEEX, RTYPEWB, MEMADR, MEMRD, MEMWB, MEMWR,
      ADDIEX, ADDIWB, BEQEX, ILLEGAL, INTR
   } stateT;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_SHIMM = 2'b11;
`ifdef MULTICYCLE_INTERRUPT_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   typedef struct packed {
      logic [1:0] aluControl;
      logic [1:0] aluSrcB;
      logic PCSource;
      logic ALUSrcA;
      logic RegWrite;
      logic RegDst;
      logic MemtoReg;
      logic PCWrite;
      logic isBranch;
      logic IRWrite;
      logic lorD;
      logic MemWrite;
      logic isInterrupted;
      logic irqAck;
      logic instrDone;
      logic illegalOp;
   } ctrlT;
   function automatic logic isTerminal(input stateT s);
      return s inside {RTYPEWB, MEMWB, MEMWR, ADDIWB, BEQEX};
   endfunction
   function automatic logic functOk(input logic [5:0] f);
      return f inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
   endfunction
endpackage

// File: rtl/multicycle_control_decode.sv
// control_output_decode: Moore output decode, state to control vector; everything forced low during reset
module control_output_decode
   import mips_ctrl_pkg::*;
(
   input stateT state,
   input logic reset,
   output ctrlT ctrl
);
   ctrlT raw;
   // per-state control values, then reset gating so an aborted state writes nothing
   always_comb begin
      raw = '0;
      raw.aluControl = state == RTYPEEX ? ALU_FUNCT : state == BEQEX ? ALU_SUB : ALU_ADD;
      raw.aluSrcB = state == FETCH ? SRCB_FOUR : state == DECODE ? SRCB_SHIMM :
                    state inside {MEMADR, ADDIEX} ? SRCB_IMM : SRCB_REG;
      raw.PCSource = state == BEQEX;
      raw.ALUSrcA = state inside {RTYPEEX, MEMADR, ADDIEX, BEQEX};
      raw.RegWrite = state inside {RTYPEWB, MEMWB, ADDIWB};
      raw.RegDst = state == RTYPEWB;
      raw.MemtoReg = state == MEMWB;
      raw.isBranch = state == BEQEX;
      raw.IRWrite = state == FETCH;
      raw.lorD = state inside {MEMRD, MEMWR};
      raw.MemWrite = state == MEMWR;
      raw.instrDone = isTerminal(state);
      raw.illegalOp = state == ILLEGAL;
`ifdef MULTICYCLE_INTERRUPT_EN
      raw.PCWrite = state inside {FETCH, INTR};
      raw.isInterrupted = state == INTR;
      raw.irqAck = state == INTR;
`else
      raw.PCWrite = state == FETCH;
      raw.isInterrupted = 1'b0;
      raw.irqAck = 1'b0;
`endif
      ctrl = reset ? '0 : raw;
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM (optional interrupt entry via MULTICYCLE_INTERRUPT_EN)
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input logic clk,
   input logic reset,
   input logic [5:0] op,
   input logic [5:0] funct,
   input logic irq,
   output logic [1:0] aluControl,
   output logic [1:0] aluSrcB,
   output logic PCSource,
   output logic ALUSrcA,
   output logic RegWrite,
   output logic RegDst,
   output logic MemtoReg,
   output logic PCWrite,
   output logic isBranch,
   output logic IRWrite,
   output logic lorD,
   output logic MemWrite,
   output logic isInterrupted,
   output logic irq_ack,
   output logic instr_done,
   output logic illegal_op
);
   stateT state;
   logic isLoad;
   ctrlT ctrl;
   control_output_decode outDecode (.state(state), .reset(reset), .ctrl(ctrl));
   assign {aluControl, aluSrcB, PCSource, ALUSrcA, RegWrite, RegDst, MemtoReg, PCWrite,
           isBranch, IRWrite, lorD, MemWrite, isInterrupted, irq_ack, instr_done, illegal_op} = ctrl;
   // state register; op is only valid in DECODE, so lw/sw is remembered for MEMADR
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         isLoad <= 1'b0;
      end else begin
         if (state == DECODE) isLoad <= op == OP_LW;
         case (state)
            FETCH: state <= DECODE;
            DECODE: state <= op == OP_RTYPE ? (functOk(funct) ? RTYPEEX : ILLEGAL) :
                             (op == OP_LW || op == OP_SW) ? MEMADR :
                             op == OP_BEQ ? BEQEX : op == OP_ADDI ? ADDIEX : ILLEGAL;
            RTYPEEX: state <= RTYPEWB;
            MEMADR: state <= isLoad ? MEMRD : MEMWR;
            MEMRD: state <= MEMWB;
            ADDIEX: state <= ADDIWB;
            RTYPEWB, MEMWB, MEMWR, ADDIWB, BEQEX: state <= (IRQ_EN && irq) ? INTR : FETCH;
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle control FSM
module tb_multicycle_control;
   import mips_ctrl_pkg::*;
`ifdef MULTICYCLE_INTERRUPT_EN
   localparam bit TB_IRQ_EN = 1'b1;
`else
   localparam bit TB_IRQ_EN = 1'b0;
`endif
   localparam logic [17:0] E_ZERO = 18'b0;
   localparam logic [17:0] E_FETCH = 18'b00_01_0_0_0_0_0_1_0_1_0_0_0_0_0_0;
   localparam logic [17:0] E_DECODE = 18'b00_11_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [17:0] E_RTEX = 18'b10_00_0_1_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [17:0] E_RTWB = 18'b00_00_0_0_1_1_0_0_0_0_0_0_0_0_1_0;
   localparam logic [17:0] E_MADR = 18'b00_10_0_1_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [17:0] E_MRD = 18'b00_00_0_0_0_0_0_0_0_0_1_0_0_0_0_0;
   localparam logic [17:0] E_MWB = 18'b00_00_0_0_1_0_1_0_0_0_0_0_0_0_1_0;
   localparam logic [17:0] E_MWR = 18'b00_00_0_0_0_0_0_0_0_0_1_1_0_0_1_0;
   localparam logic [17:0] E_AWB = 18'b00_00_0_0_1_0_0_0_0_0_0_0_0_0_1_0;
   localparam logic [17:0] E_BEQ = 18'b01_00_1_1_0_0_0_0_1_0_0_0_0_0_1_0;
   localparam logic [17:0] E_ILL = 18'b00_00_0_0_0_0_0_0_0_0_0_0_0_0_0_1;
   localparam logic [17:0] E_INTR = 18'b00_00_0_0_0_0_0_1_0_0_0_0_1_1_0_0;
   logic clk = 1'b0, reset = 1'b1, irq = 1'b0;
   logic [5:0] op = 6'd0, funct = 6'd0;
   logic [1:0] aluControl, aluSrcB;
   logic PCSource, ALUSrcA, RegWrite, RegDst, MemtoReg, PCWrite, isBranch, IRWrite;
   logic lorD, MemWrite, isInterrupted, irq_ack, instr_done, illegal_op;
   logic [17:0] obs;
   typedef struct {
      string tag;
      logic [17:0] v;
   } expT;
   expT sb[$];
   int compared = 0, mismatched = 0;
   always #5 clk = ~clk;
   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
      .aluControl(aluControl), .aluSrcB(aluSrcB), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCWrite(PCWrite),
      .isBranch(isBranch), .IRWrite(IRWrite), .lorD(lorD), .MemWrite(MemWrite),
      .isInterrupted(isInterrupted), .irq_ack(irq_ack), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );
   assign obs = {aluControl, aluSrcB, PCSource, ALUSrcA, RegWrite, RegDst, MemtoReg, PCWrite,
                 isBranch, IRWrite, lorD, MemWrite, isInterrupted, irq_ack, instr_done, illegal_op};
   task automatic checkEq(input string tag, input logic [17:0] got, input logic [17:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic push(input string t, input logic [17:0] v);
      expT e;
      e.tag = t;
      e.v = v;
      sb.push_back(e);
   endtask
   task automatic pushTerm(input string t, input logic [17:0] v, input logic irqv);
      push(t, v);
      if (TB_IRQ_EN && irqv) push({t, "_intr"}, E_INTR);
   endtask
   task automatic pushModel(input logic [5:0] o, input logic [5:0] f, input logic irqv);
      push("fetch", E_FETCH);
      push("decode", E_DECODE);
      case (o)
         6'b000000:
            if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
               push("rtex", E_RTEX);
               pushTerm("rtwb", E_RTWB, irqv);
            end else push("ill_funct", E_ILL);
         6'b100011: begin
            push("lw_adr", E_MADR);
            push("lw_rd", E_MRD);
            pushTerm("lw_wb", E_MWB, irqv);
         end
         6'b101011: begin
            push("sw_adr", E_MADR);
            pushTerm("sw_wr", E_MWR, irqv);
         end
         6'b000100: pushTerm("beq", E_BEQ, irqv);
         6'b001000: begin
            push("addi_ex", E_MADR);
            pushTerm("addi_wb", E_AWB, irqv);
         end
         default: push("ill_op", E_ILL);
      endcase
   endtask
   // op/funct are scrambled after DECODE to show they are only sampled there
   task automatic drain();
      int i = 0;
      while (sb.size() > 0) begin
         expT e = sb.pop_front();
         @(negedge clk);
         checkEq(e.tag, obs, e.v);
         @(posedge clk);
         #1;
         if (i >= 1) begin
            op = 6'($urandom);
            funct = 6'($urandom);
         end
         i++;
      end
   endtask
   task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic irqv);
      op = o;
      funct = f;
      irq = irqv;
      pushModel(o, f, irqv);
      drain();
      irq = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      push("reset", E_ZERO);
      drain();
      reset = 1'b0;
      runInstr(OP_RTYPE, FUNCT_ADD, 1'b0);
      runInstr(OP_LW, 6'd0, 1'b0);
      runInstr(OP_SW, 6'd0, 1'b0);
      runInstr(OP_BEQ, 6'd0, 1'b0);
      runInstr(6'b111111, 6'd0, 1'b0);
      runInstr(OP_RTYPE, 6'b000000, 1'b0);
      runInstr(OP_RTYPE, FUNCT_SUB, 1'b0);
      runInstr(OP_RTYPE, FUNCT_AND, 1'b0);
      runInstr(OP_RTYPE, FUNCT_OR, 1'b0);
      runInstr(OP_RTYPE, FUNCT_SLT, 1'b0);
      runInstr(OP_RTYPE, 6'b100001, 1'b0);
      runInstr(OP_ADDI, 6'd0, 1'b1);
      runInstr(OP_ADDI, 6'd0, 1'b1);
      runInstr(OP_ADDI, 6'd0, 1'b0);
      runInstr(6'b000010, 6'd0, 1'b1);
      runInstr(OP_LW, 6'd0, 1'b1);
      op = OP_SW;
      funct = 6'd0;
      push("mid_fetch", E_FETCH);
      push("mid_decode", E_DECODE);
      push("mid_adr", E_MADR);
      drain();
      reset = 1'b1;
      push("rst_memwr", E_ZERO);
      drain();
      reset = 1'b0;
      runInstr(OP_LW, 6'd0, 1'b0);
      runInstr(OP_BEQ, 6'd0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
